// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one shift-add sign-magnitude multiplier
// between two requesters and returns each product tagged with its owner.
module mult_arbiter #(
  parameter int MAX_WAIT = 9,
  parameter int CNT_W    = 8
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        mul_start,
  output logic [7:0]  mul_multiplier,
  output logic [7:0]  mul_multiplicand,
  input  logic        mul_zflag,
  input  logic [13:0] mul_result,
  input  logic [3:0]  mul_sign,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [13:0] rsp_result,
  output logic [3:0]  rsp_sign,
  output logic        rsp_err,
  output logic [1:0]  fsm_state
);

  // Handshake: a requester holds req until it sees its gnt bit; gnt is a
  // one-cycle pulse in IDLE and the operands are latched on that same edge.
  // rsp_valid is a one-cycle pulse with no back-pressure.

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [3:0] SIGN_POS = 4'b1100;

  state_t           state_q, state_d;
  logic             ptr_q;
  logic             id_q;
  logic [7:0]       a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             win;
  logic             timeout;

  assign timeout          = (cnt_q == CNT_W'(MAX_WAIT - 1));
  assign busy             = (state_q != IDLE);
  assign mul_start        = (state_q == LOAD);
  assign rsp_valid        = (state_q == DONE);
  assign rsp_id           = id_q;
  assign mul_multiplier   = a_q;
  assign mul_multiplicand = b_q;
  assign fsm_state        = state_q;

  // A lone request wins outright; a tie goes to the priority pointer.
  always_comb begin
    win = (req == 2'b11) ? ptr_q : req[1];
  end

  always_comb begin
    state_d = state_q;
    gnt     = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt     = win ? 2'b10 : 2'b01;
          state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (mul_zflag || timeout) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      cnt_q      <= '0;
      rsp_result <= 14'd0;
      rsp_sign   <= SIGN_POS;
      rsp_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|req) begin
            id_q  <= win;
            ptr_q <= ~win;
            a_q   <= win ? a1 : a0;
            b_q   <= win ? b1 : b0;
          end
        end
        LOAD: cnt_q <= '0;
        RUN: begin
          // A finished multiply beats a timeout landing on the same cycle.
          if (mul_zflag) begin
            rsp_result <= mul_result;
            rsp_sign   <= mul_sign;
            rsp_err    <= 1'b0;
          end else if (timeout) begin
            rsp_result <= 14'd0;
            rsp_sign   <= SIGN_POS;
            rsp_err    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: a behavioural shift-add multiplier plus a
// scoreboard that predicts every response (id, product, sign, latency).
module tb_mult_arbiter;

  logic        clock = 1'b0;
  logic        rst;
  logic        force_z;
  logic [1:0]  req;
  logic [7:0]  a0, b0, a1, b1;
  logic [1:0]  gnt;
  logic        busy;
  logic        mul_start;
  logic [7:0]  mul_multiplier, mul_multiplicand;
  logic        mul_zflag;
  logic [13:0] mul_result;
  logic [3:0]  mul_sign;
  logic        rsp_valid;
  logic        rsp_id;
  logic [13:0] rsp_result;
  logic [3:0]  rsp_sign;
  logic        rsp_err;
  logic [1:0]  fsm_state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [19:0] exp_q[$];
  int          due_q[$];

  mult_arbiter #(.MAX_WAIT(9), .CNT_W(8)) dut (
    .clock(clock), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .mul_start(mul_start),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_zflag(mul_zflag), .mul_result(mul_result), .mul_sign(mul_sign),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_sign(rsp_sign), .rsp_err(rsp_err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- multiplier model ----------------
  logic [6:0]  m_reg;
  logic [13:0] m_acc, m_cand;

  always @(posedge clock) begin
    if (rst) begin
      m_reg  <= 7'd0;
      m_acc  <= 14'd0;
      m_cand <= 14'd0;
    end else if (mul_start) begin
      m_reg  <= mul_multiplier[6:0];
      m_cand <= {7'd0, mul_multiplicand[6:0]};
      m_acc  <= 14'd0;
    end else if (m_reg != 7'd0) begin
      if (m_reg[0]) m_acc <= m_acc + m_cand;
      m_cand <= m_cand << 1;
      m_reg  <= m_reg >> 1;
    end
  end

  assign mul_zflag  = !force_z && (m_reg == 7'd0);
  assign mul_result = m_acc;
  assign mul_sign   = (mul_multiplier[7] ^ mul_multiplicand[7]) ? 4'b1010 : 4'b1100;

  // ---------------- scoreboard ----------------
  logic        s_id;
  logic [7:0]  s_a, s_b;
  logic [13:0] s_prod;
  logic [3:0]  s_sign;
  int          s_len;
  logic [19:0] s_exp;
  int          s_due;

  always @(negedge clock) begin
    if (!rst) begin
      if (gnt != 2'b00) begin
        tests++;
        assert (busy === 1'b0 && (gnt === 2'b01 || gnt === 2'b10)) else begin
          fails++;
          $error("FAIL gnt_idle: gnt=%b busy=%b, required one-hot gnt with busy=0", gnt, busy);
        end
        s_id   = gnt[1];
        s_a    = s_id ? a1 : a0;
        s_b    = s_id ? b1 : b0;
        s_prod = 14'(s_a[6:0]) * 14'(s_b[6:0]);
        s_sign = (s_a[7] ^ s_b[7]) ? 4'b1010 : 4'b1100;
        s_len  = 0;
        for (int i = 0; i < 7; i++) if (s_a[i]) s_len = i + 1;
        if (force_z) begin
          exp_q.push_back({s_id, 1'b1, 4'b1100, 14'd0});
          due_q.push_back(cyc + 11);
        end else begin
          exp_q.push_back({s_id, 1'b0, s_sign, s_prod});
          due_q.push_back(cyc + s_len + 3);
        end
      end
      if (rsp_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $error("FAIL rsp_unexpected: rsp_valid=1 id=%0d result=%0d, required no response", rsp_id, rsp_result);
        end else begin
          s_exp = exp_q.pop_front();
          s_due = due_q.pop_front();
          assert ({rsp_id, rsp_err, rsp_sign, rsp_result} === s_exp) else begin
            fails++;
            $error("FAIL rsp_fields: id=%0d err=%0d sign=%b result=%0d, required id=%0d err=%0d sign=%b result=%0d",
                   rsp_id, rsp_err, rsp_sign, rsp_result, s_exp[19], s_exp[18], s_exp[17:14], s_exp[13:0]);
          end
          tests++;
          assert (cyc === s_due) else begin
            fails++;
            $error("FAIL rsp_latency: response at cycle %0d, required cycle %0d", cyc, s_due);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, input logic [1:0] exp);
    int n = 0;
    @(negedge clock);
    while (gnt == 2'b00 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(gnt), 32'(exp));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 60) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_req(input string tag, input logic id, input logic [7:0] a, input logic [7:0] b);
    @(posedge clock); #1;
    if (id) begin a1 = a; b1 = b; req = 2'b10; end
    else    begin a0 = a; b0 = b; req = 2'b01; end
    wait_gnt({tag, "_gnt"}, id ? 2'b10 : 2'b01);
    @(posedge clock); #1;
    req = 2'b00;
    @(negedge clock);
    check({tag, "_start"}, 32'(mul_start), 32'd1);
    check({tag, "_opa"}, 32'(mul_multiplier), 32'(a));
    check({tag, "_opb"}, 32'(mul_multiplicand), 32'(b));
    wait_done({tag, "_done"});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; force_z = 1'b0; req = 2'b00;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(mul_start), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_sign", 32'(rsp_sign), 32'hC);
    check("rst_err", 32'(rsp_err), 32'd0);
    @(posedge clock); #1;
    rst = 1'b0;

    do_req("basic0", 1'b0, 8'h05, 8'h03);
    do_req("neg1", 1'b1, 8'h85, 8'h7F);

    // Both requesters held: grants must alternate starting from requester 0.
    @(posedge clock); #1;
    a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
    a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
    req = 2'b11;
    for (int i = 0; i < 4; i++) wait_gnt("fair_gnt", (i % 2 == 1) ? 2'b10 : 2'b01);
    @(posedge clock); #1;
    req = 2'b00;
    wait_done("fair_done");

    do_req("zero_a", 1'b0, 8'h00, 8'h7F);
    do_req("max_ops", 1'b0, 8'hFF, 8'hFF);
    for (int i = 0; i < 3; i++)
      do_req("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    force_z = 1'b1;
    do_req("timeout", 1'b0, 8'h03, 8'h04);
    force_z = 1'b0;
    check("timeout_err_held", 32'(rsp_err), 32'd1);
    do_req("after_to", 1'b1, 8'h02, 8'h09);
    check("after_to_err", 32'(rsp_err), 32'd0);

    // Abort an operation in RUN; the pointer (left at 1) must return to 0.
    @(posedge clock); #1;
    a0 = 8'h7F; b0 = 8'h01; a1 = 8'h03; b1 = 8'h03;
    req = 2'b01;
    wait_gnt("pre_rst_gnt", 2'b01);
    @(posedge clock); #1;
    req = 2'b00;
    @(posedge clock); #1;
    check("pre_rst_run", 32'(fsm_state), 32'd2);
    rst = 1'b1; req = 2'b11;
    @(posedge clock); #1;
    rst = 1'b0;
    exp_q.delete();
    due_q.delete();
    @(negedge clock);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_start", 32'(mul_start), 32'd0);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_gnt", 32'(gnt), 32'd1);
    @(posedge clock); #1;
    req = 2'b00;
    wait_done("post_rst_done");

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
